// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: decode/execute descriptors,
// the mul/div start/done handshake, and the per-stage stall/flush controls.
// Signal suffixes are written from the controller's point of view.
interface hazard_ctrl_if;
    logic       valid_d_i;
    logic [4:0] rs1_d_i;
    logic [4:0] rs2_d_i;
    logic       valid_e_i;
    logic [4:0] rd_e_i;
    logic       load_e_i;
    logic       md_op_e_i;
    logic       mispredict_e_i;
    logic       md_done_i;
    logic       md_start_o;
    logic       stall_f_o;
    logic       stall_d_o;
    logic       stall_e_o;
    logic       flush_d_o;
    logic       flush_e_o;
    logic       flush_m_o;

    // Controller side
    modport slave (
        input  valid_d_i, rs1_d_i, rs2_d_i,
        input  valid_e_i, rd_e_i, load_e_i, md_op_e_i, mispredict_e_i,
        input  md_done_i,
        output md_start_o,
        output stall_f_o, stall_d_o, stall_e_o,
        output flush_d_o, flush_e_o, flush_m_o
    );

    // Pipeline / environment side
    modport master (
        output valid_d_i, rs1_d_i, rs2_d_i,
        output valid_e_i, rd_e_i, load_e_i, md_op_e_i, mispredict_e_i,
        output md_done_i,
        input  md_start_o,
        input  stall_f_o, stall_d_o, stall_e_o,
        input  flush_d_o, flush_e_o, flush_m_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core.
// Resolves load-use hazards, execute-stage mispredicts and multi-cycle
// mul/div operations, and keeps free-running stall/flush counters.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no mul/div in flight; a mul/div arriving in E is launched
//   BUSY   | mul/div launched, waiting for the one-cycle done pulse
//
// All stall/flush/start outputs are combinational so they act in the
// same cycle as the hazard; only the FSM state and counters are flops.
module hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    hazard_ctrl_if.slave         hz,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic md_stall;
    logic md_launch;
    logic md_finish;
    logic stall_front;

    // Hazard terms shared by the next-state and output logic
    always_comb begin
        lu = hz.load_e_i & hz.valid_e_i & hz.valid_d_i &
             (hz.rd_e_i != 5'd0) &
             ((hz.rd_e_i == hz.rs1_d_i) | (hz.rd_e_i == hz.rs2_d_i));
        // Done only counts once the op has been launched; a done in the
        // launch cycle cannot belong to this op.
        md_finish = (state_q == S_BUSY) & hz.md_done_i;
        md_stall  = hz.valid_e_i & hz.md_op_e_i & ~md_finish;
        md_launch = (state_q == S_IDLE) & hz.valid_e_i & hz.md_op_e_i;
        stall_front = lu | md_stall;
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (md_launch) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (hz.md_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and hazard outputs; a launch is suppressed while reset is held
    // because the long-latency unit is being reset in the same cycle.
    always_comb begin
        hz.md_start_o = md_launch & ~reset_i;
        hz.stall_f_o  = stall_front;
        hz.stall_d_o  = stall_front;
        hz.stall_e_o  = md_stall;
        hz.flush_m_o  = md_stall;
        // While E is frozen by mul/div, a load-use in D needs no bubble.
        hz.flush_e_o  = (lu & ~md_stall) | hz.mispredict_e_i;
        hz.flush_d_o  = hz.mispredict_e_i;
    end

    // Performance counter next values, wrapping naturally at full width
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_front) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (hz.mispredict_e_i) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .hz          (hz),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_busy;
    int m_stall_cnt;
    int m_flush_cnt;
    int cyc;

    // Output vector: {md_start, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
    function automatic logic [6:0] obs();
        return {hz.md_start_o, hz.stall_f_o, hz.stall_d_o, hz.stall_e_o,
                hz.flush_d_o, hz.flush_e_o, hz.flush_m_o};
    endfunction

    function automatic logic [6:0] expected();
        bit hazard, mc, start, mp;
        hazard = hz.load_e_i && hz.valid_e_i && hz.valid_d_i && hz.rd_e_i != 0 &&
                 (hz.rd_e_i == hz.rs1_d_i || hz.rd_e_i == hz.rs2_d_i);
        mc     = hz.valid_e_i && hz.md_op_e_i && !(m_busy && hz.md_done_i);
        start  = !reset && !m_busy && hz.valid_e_i && hz.md_op_e_i;
        mp     = hz.mispredict_e_i;
        return {start, hazard || mc, hazard || mc, mc, mp, (hazard && !mc) || mp, mc};
    endfunction

    // Advance one clock and the model alongside it
    task automatic tick();
        logic [6:0] e;
        @(posedge clk);
        e = expected();
        if (reset) begin
            m_busy = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (e[5]) m_stall_cnt = (m_stall_cnt + 1) % (1 << CW);
            if (hz.mispredict_e_i) m_flush_cnt = (m_flush_cnt + 1) % (1 << CW);
            if (!m_busy && hz.valid_e_i && hz.md_op_e_i) m_busy = 1;
            else if (m_busy && hz.md_done_i) m_busy = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input bit vd, input int rs1, input int rs2, input bit ve,
                         input int rd, input bit ld, input bit md, input bit mp,
                         input bit done);
        hz.valid_d_i      = vd;
        hz.rs1_d_i        = 5'(rs1);
        hz.rs2_d_i        = 5'(rs2);
        hz.valid_e_i      = ve;
        hz.rd_e_i         = 5'(rd);
        hz.load_e_i       = ld;
        hz.md_op_e_i      = md;
        hz.mispredict_e_i = mp;
        hz.md_done_i      = done;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 7'b0);
        end
        checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 3, 5, 1, 5, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0110010) begin
            errors++; $display("FAIL load_use_bubble got=%b exp=%b", obs(), 7'b0110010);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL load_use_clear got=%b exp=%b", obs(), 7'b0);
        end
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        drive(1, 0, 7, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL load_x0 got=%b exp=%b", obs(), 7'b0);
        end
        tick();
        drive(0, 5, 5, 1, 5, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL load_invalid_d got=%b exp=%b", obs(), 7'b0);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++; $display("FAIL no_hazard_cnt got=%0d exp=0", stall_cnt);
        end
    endtask

    task automatic test_multicycle();
        logic [6:0] e;
        int starts = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 7, 0, 1, 0, i == 4);
            @(negedge clk);
            e = (i == 0) ? 7'b1111001 : (i < 4) ? 7'b0111001 : 7'b0;
            if (hz.md_start_o) starts++;
            checks++;
            if (obs() !== e) begin
                errors++; $display("FAIL md_cycle%0d got=%b exp=%b", i, obs(), e);
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (starts != 1) begin
            errors++; $display("FAIL md_start_pulses got=%0d exp=1", starts);
        end
        checks++;
        if (stall_cnt !== 4'd4) begin
            errors++; $display("FAIL md_stall_cnt got=%0d exp=4", stall_cnt);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1, 1, 2, 1, 3, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0000110) begin
            errors++; $display("FAIL mispredict_flush got=%b exp=%b", obs(), 7'b0000110);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL mispredict_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive(0, 0, 0, 1, 7, 0, 1, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (hz.md_start_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy_start got=%b exp=0", hz.md_start_o);
        end
        tick();
        reset = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
            errors++; $display("FAIL reset_busy_after got=%b cnt=%0d/%0d exp=0 cnt=0/0",
                               obs(), stall_cnt, flush_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL stray_done got=%b exp=%b", obs(), 7'b0);
        end
        tick();
        drive(0, 0, 0, 1, 7, 0, 1, 0, 1);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b1111001) begin
            errors++; $display("FAIL done_in_idle got=%b exp=%b", obs(), 7'b1111001);
        end
        tick();
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++; $display("FAIL done_after_start got=%b exp=%b", obs(), 7'b0);
        end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, n = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 8) drive(0, 0, 0, 1, 9, 0, 1, 0, c == 3 || c == 7);
            else idle();
            @(negedge clk);
            checks++;
            if (obs() !== expected()) begin
                errors++; $display("FAIL b2b_cycle%0d got=%b exp=%b", c, obs(), expected());
            end
            if (hz.md_start_o === 1'b1) begin
                if (n == 0) first = c; else second = c;
                n++;
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (n != 2 || second - first != 4) begin
            errors++; $display("FAIL b2b_starts got=%0d gap=%0d exp=2 gap=4", n, second - first);
        end
        checks++;
        if (stall_cnt !== 4'd6) begin
            errors++; $display("FAIL b2b_stall_cnt got=%0d exp=6", stall_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 4, 0, 1, 4, 1, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (stall_cnt !== CW'(i % 16)) begin
                errors++; $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, stall_cnt, i % 16);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        int kind;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(3);
            reset = ($urandom_range(49) == 0);
            drive($urandom_range(1), $urandom_range(3), $urandom_range(3), $urandom_range(1),
                  $urandom_range(3), kind == 1, kind == 2, kind == 3, $urandom_range(2) == 0);
            @(negedge clk);
            checks++;
            if (obs() !== expected()) begin
                errors++; $display("FAIL rand_out%0d got=%b exp=%b", i, obs(), expected());
            end
            checks++;
            if (stall_cnt !== CW'(m_stall_cnt) || flush_cnt !== CW'(m_flush_cnt)) begin
                errors++; $display("FAIL rand_cnt%0d got=%0d/%0d exp=%0d/%0d", i,
                                   stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        m_busy = 0; m_stall_cnt = 0; m_flush_cnt = 0; cyc = 0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_multicycle();
        test_mispredict();
        test_reset_busy();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
